// File: rtl/cmos_pixel_capture.sv
// Packs BYTES_PER_PIX sensor bytes into one pixel, with crop, frame decimation and frame counting; 2 pclk latency.
// No backpressure: one pixel at most every BYTES_PER_PIX cycles, dropped lines/frames are simply not emitted.
module cmos_pixel_capture #(
   parameter int IN_W          = 8,
   parameter int BYTES_PER_PIX = 2,
   parameter int OUT_W         = IN_W*BYTES_PER_PIX,
   parameter int CNT_W         = 12,
   parameter bit MSB_FIRST     = 1'b1
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic [IN_W-1:0]  pdata_i,
   input  logic             vsync_i,
   input  logic             href_i,
   input  logic [CNT_W-1:0] x_start_i,
   input  logic [CNT_W-1:0] x_end_i,
   input  logic [CNT_W-1:0] y_start_i,
   input  logic [CNT_W-1:0] y_end_i,
   input  logic [3:0]       skip_i,
   input  logic             rb_swap_i,
   output logic [OUT_W-1:0] pdata_o,
   output logic             de_o,
   output logic             sof_o,
   output logic             eol_o,
   output logic [15:0]      frame_cnt_o,
   output logic             err_o
);

   localparam int PH_W = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
   localparam logic [PH_W-1:0]  PH_LAST = PH_W'(BYTES_PER_PIX-1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [IN_W-1:0]  d_r;
   logic             vs_r, hr_r, vs_d, hr_d;
   logic             vs_fall, hr_fall;

   logic [CNT_W-1:0] xs_sh, xe_sh, ys_sh, ye_sh;
   logic             rb_sh;
   logic [3:0]       skip_cnt;
   logic             accept, frame_active, first_pix, line_seen;
   logic [CNT_W-1:0] x, y;
   logic [PH_W-1:0]  phase;
   logic [OUT_W-1:0] asm_r, asm_next, pix_word;
   logic             pix_done, in_win;

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         d_r  <= '0;
         vs_r <= 1'b0;
         hr_r <= 1'b0;
         vs_d <= 1'b0;
         hr_d <= 1'b0;
      end else begin
         d_r  <= pdata_i;
         vs_r <= vsync_i;
         hr_r <= href_i;
         vs_d <= vs_r;
         hr_d <= hr_r;
      end
   end

   assign vs_fall  = vs_d & ~vs_r;
   assign hr_fall  = hr_d & ~hr_r;
   assign pix_done = (phase == PH_LAST);
   assign in_win   = accept && (x >= xs_sh) && (x <= xe_sh) && (y >= ys_sh) && (y <= ye_sh);

   // Byte 0 is shifted toward the end chosen by MSB_FIRST as later bytes arrive.
   always_comb begin
      if (MSB_FIRST) asm_next = (asm_r << IN_W) | OUT_W'(d_r);
      else           asm_next = (asm_r >> IN_W) | (OUT_W'(d_r) << (OUT_W-IN_W));
   end

   generate
      if (OUT_W == 16) begin : g_rb
         assign pix_word = rb_sh ? {asm_next[4:0], asm_next[10:5], asm_next[15:11]} : asm_next;
      end else begin : g_no_rb
         assign pix_word = asm_next;
      end
   endgenerate

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         pdata_o      <= '0;
         de_o         <= 1'b0;
         sof_o        <= 1'b0;
         eol_o        <= 1'b0;
         err_o        <= 1'b0;
         frame_cnt_o  <= '0;
         xs_sh        <= '0;
         xe_sh        <= '0;
         ys_sh        <= '0;
         ye_sh        <= '0;
         rb_sh        <= 1'b0;
         skip_cnt     <= '0;
         accept       <= 1'b0;
         frame_active <= 1'b0;
         first_pix    <= 1'b0;
         line_seen    <= 1'b0;
         x            <= '0;
         y            <= '0;
         phase        <= '0;
         asm_r        <= '0;
      end else begin
         de_o  <= 1'b0;
         sof_o <= 1'b0;
         eol_o <= 1'b0;
         err_o <= 1'b0;
         if (vs_r) begin
            // Vertical blank silently abandons any half-built pixel.
            frame_active <= 1'b0;
            phase        <= '0;
            line_seen    <= 1'b0;
         end else if (vs_fall) begin
            xs_sh        <= x_start_i;
            xe_sh        <= x_end_i;
            ys_sh        <= y_start_i;
            ye_sh        <= y_end_i;
            rb_sh        <= rb_swap_i;
            x            <= '0;
            y            <= '0;
            phase        <= '0;
            first_pix    <= 1'b1;
            line_seen    <= 1'b0;
            frame_active <= 1'b1;
            accept       <= (skip_cnt == 4'd0);
            skip_cnt     <= (skip_cnt >= skip_i) ? 4'd0 : skip_cnt + 4'd1;
            if (skip_cnt == 4'd0) frame_cnt_o <= frame_cnt_o + 16'd1;
         end else if (frame_active) begin
            if (hr_r) begin
               asm_r     <= asm_next;
               line_seen <= 1'b1;
               if (pix_done) begin
                  phase   <= '0;
                  pdata_o <= pix_word;
                  de_o    <= in_win;
                  sof_o   <= in_win & first_pix;
                  eol_o   <= in_win & (x == xe_sh);
                  if (in_win) first_pix <= 1'b0;
                  if (x != CNT_MAX) x <= x + CNT_W'(1);
               end else begin
                  phase <= phase + PH_W'(1);
               end
            end else if (hr_fall) begin
               err_o <= (phase != '0);
               x     <= '0;
               phase <= '0;
               if (line_seen && (y != CNT_MAX)) y <= y + CNT_W'(1);
               line_seen <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cmos_pixel_capture.sv
// Bench for cmos_pixel_capture: directed scenarios plus randomized frames checked against a per-frame event model.
module tb_cmos_pixel_capture;

   logic        pclk = 1'b0;
   logic        rst;
   logic [7:0]  pdata_i;
   logic        vsync_i, href_i;
   logic [11:0] x_start_i, x_end_i, y_start_i, y_end_i;
   logic [3:0]  skip_i;
   logic        rb_swap_i;
   logic [15:0] pdata_o;
   logic        de_o, sof_o, eol_o, err_o;
   logic [15:0] frame_cnt_o;

   cmos_pixel_capture dut (
      .pclk(pclk), .rst(rst), .pdata_i(pdata_i), .vsync_i(vsync_i), .href_i(href_i),
      .x_start_i(x_start_i), .x_end_i(x_end_i), .y_start_i(y_start_i), .y_end_i(y_end_i),
      .skip_i(skip_i), .rb_swap_i(rb_swap_i), .pdata_o(pdata_o), .de_o(de_o), .sof_o(sof_o),
      .eol_o(eol_o), .frame_cnt_o(frame_cnt_o), .err_o(err_o)
   );

   always #5 pclk = ~pclk;

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   typedef struct {
      int          c;
      logic [15:0] d;
      logic        de, sof, eol;
   } ev_t;

   ev_t act_q[$], exp_q[$];
   int  act_err[$], exp_err[$];
   int  checks = 0, errors = 0;
   int  m_skip = 0, m_fcnt = 0;

   int          nlines;
   int          llen[8];
   logic [7:0]  fb[8][32];
   bit          coin = 0, cfg_change = 0;

   always @(negedge pclk) begin
      if (!rst) begin
         if (de_o | sof_o | eol_o) act_q.push_back('{cyc, pdata_o, de_o, sof_o, eol_o});
         if (err_o) act_err.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick(input logic vs, input logic hr, input logic [7:0] d);
      @(negedge pclk);
      vsync_i = vs;
      href_i  = hr;
      pdata_i = d;
   endtask

   task automatic set_cfg(input int xs, input int xe, input int ys, input int ye, input int sk, input bit rb);
      x_start_i = 12'(xs);
      x_end_i   = 12'(xe);
      y_start_i = 12'(ys);
      y_end_i   = 12'(ye);
      skip_i    = 4'(sk);
      rb_swap_i = rb;
   endtask

   task automatic clear_q();
      act_q.delete();
      exp_q.delete();
      act_err.delete();
      exp_err.delete();
   endtask

   task automatic do_reset();
      @(negedge pclk);
      rst = 1'b1;
      repeat (2) @(negedge pclk);
      rst = 1'b0;
      m_skip = 0;
      m_fcnt = 0;
      clear_q();
   endtask

   // Drives one frame and predicts its output events from the capture rules.
   task automatic run_frame();
      int  xs, xe, ys, ye, sk, x, y, e, n;
      bit  rb, acc, first, win;
      logic [15:0] pix;
      repeat (3) tick(1'b1, 1'b0, 8'($urandom));
      xs = int'(x_start_i); xe = int'(x_end_i);
      ys = int'(y_start_i); ye = int'(y_end_i);
      sk = int'(skip_i);    rb = rb_swap_i;
      acc = (m_skip == 0);
      m_skip = (m_skip >= sk) ? 0 : m_skip + 1;
      if (acc) m_fcnt++;
      first = 1'b1;
      y = 0;
      if (!coin) tick(1'b0, 1'b0, 8'($urandom));
      for (int l = 0; l < nlines; l++) begin
         if (!(coin && l == 0)) repeat (1 + $urandom_range(0, 2)) tick(1'b0, 1'b0, 8'($urandom));
         x = 0;
         n = 0;
         for (int b = 0; b < llen[l]; b++) begin
            tick(1'b0, 1'b1, fb[l][b]);
            e = cyc + 1;
            if (!(coin && l == 0 && b == 0)) begin
               n++;
               if (n % 2 == 0) begin
                  pix = {fb[l][b-1], fb[l][b]};
                  if (rb) pix = {pix[4:0], pix[10:5], pix[15:11]};
                  win = acc && x >= xs && x <= xe && y >= ys && y <= ye;
                  if (win) exp_q.push_back('{e + 1, pix, 1'b1, first, x == xe});
                  if (win) first = 1'b0;
                  x++;
               end
            end
         end
         tick(1'b0, 1'b0, 8'($urandom));
         e = cyc + 1;
         if (n % 2 != 0) exp_err.push_back(e + 1);
         if (n > 0) y++;
         if (cfg_change && l == 0)
            set_cfg($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 4),
                    $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom));
      end
      repeat (3) tick(1'b0, 1'b0, 8'($urandom));
   endtask

   task automatic compare_frame(input string tag);
      int n;
      @(negedge pclk);
      #1;
      check({tag, "_de_count"}, 64'(act_q.size()), 64'(exp_q.size()));
      n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check({tag, "_cycle"}, 64'(act_q[i].c), 64'(exp_q[i].c));
         check({tag, "_pdata"}, 64'(act_q[i].d), 64'(exp_q[i].d));
         check({tag, "_de"},    64'(act_q[i].de), 64'(exp_q[i].de));
         check({tag, "_sof"},   64'(act_q[i].sof), 64'(exp_q[i].sof));
         check({tag, "_eol"},   64'(act_q[i].eol), 64'(exp_q[i].eol));
      end
      check({tag, "_err_count"}, 64'(act_err.size()), 64'(exp_err.size()));
      n = (act_err.size() < exp_err.size()) ? act_err.size() : exp_err.size();
      for (int i = 0; i < n; i++) check({tag, "_err_cycle"}, 64'(act_err[i]), 64'(exp_err[i]));
      check({tag, "_frame_cnt"}, 64'(frame_cnt_o), 64'(m_fcnt));
   endtask

   task automatic fill_ab(input int nl, input int nb);
      nlines = nl;
      for (int l = 0; l < nl; l++) begin
         llen[l] = nb;
         for (int k = 0; k < nb / 2; k++) begin
            fb[l][2*k]   = 8'hA0 + 8'(k);
            fb[l][2*k+1] = 8'hB0 + 8'(k);
         end
      end
   endtask

   task automatic fill_rand(input int nl, input int maxb);
      nlines = nl;
      for (int l = 0; l < nl; l++) begin
         llen[l] = $urandom_range(1, maxb);
         for (int b = 0; b < 32; b++) fb[l][b] = 8'($urandom);
      end
   endtask

   initial begin
      int mask;
      rst = 1'b1;
      pdata_i = 8'h00; vsync_i = 1'b0; href_i = 1'b0;
      set_cfg(0, 4095, 0, 4095, 0, 1'b0);
      repeat (3) @(negedge pclk);
      #1;
      check("rst_pdata", 64'(pdata_o), 64'(0));
      check("rst_de", 64'(de_o), 64'(0));
      check("rst_sof", 64'(sof_o), 64'(0));
      check("rst_eol", 64'(eol_o), 64'(0));
      check("rst_frame_cnt", 64'(frame_cnt_o), 64'(0));
      check("rst_err", 64'(err_o), 64'(0));
      @(negedge pclk);
      rst = 1'b0;

      // Basic 4x2 frame of A0,B0,A1,B1,...
      set_cfg(0, 3, 0, 1, 0, 1'b0);
      fill_ab(2, 8);
      run_frame();
      compare_frame("basic");
      check("basic_npix", 64'(act_q.size()), 64'(8));
      if (act_q.size() > 0) check("basic_first_pix", 64'(act_q[0].d), 64'(16'hA0B0));
      check("basic_frame_cnt_one", 64'(frame_cnt_o), 64'(1));
      clear_q();

      // Red/blue swap of 0xF800.
      set_cfg(0, 4095, 0, 4095, 0, 1'b1);
      nlines = 1; llen[0] = 2; fb[0][0] = 8'hF8; fb[0][1] = 8'h00;
      run_frame();
      compare_frame("rbswap");
      if (act_q.size() > 0) check("rbswap_value", 64'(act_q[0].d), 64'(16'h001F));
      clear_q();

      // Crop window x 2..3, y 1..1 on 4x3.
      set_cfg(2, 3, 1, 1, 0, 1'b0);
      fill_ab(3, 8);
      run_frame();
      compare_frame("crop");
      check("crop_npix", 64'(act_q.size()), 64'(2));
      clear_q();

      // Odd-length line, then a clean line.
      set_cfg(0, 4095, 0, 4095, 0, 1'b0);
      fill_rand(2, 8);
      llen[0] = 7; llen[1] = 8;
      run_frame();
      compare_frame("partial");
      check("partial_npix", 64'(act_q.size()), 64'(7));
      check("partial_nerr", 64'(act_err.size()), 64'(1));
      clear_q();

      // vsync fall coinciding with href high drops that first byte.
      coin = 1;
      fill_rand(2, 8);
      llen[0] = 5; llen[1] = 4;
      run_frame();
      coin = 0;
      compare_frame("coincident");
      check("coincident_nerr", 64'(act_err.size()), 64'(0));
      clear_q();

      // Inverted crop: no pixels, frame still counted.
      set_cfg(5, 2, 0, 4095, 0, 1'b0);
      fill_rand(2, 10);
      run_frame();
      compare_frame("empty_crop");
      check("empty_crop_npix", 64'(act_q.size()), 64'(0));
      clear_q();

      // Config changes mid-frame are ignored until the next frame.
      set_cfg(1, 6, 0, 2, 0, 1'b1);
      cfg_change = 1;
      fill_rand(4, 16);
      run_frame();
      cfg_change = 0;
      compare_frame("midcfg");
      clear_q();

      // Decimation: skip 2 over 6 frames from reset.
      do_reset();
      set_cfg(0, 4095, 0, 4095, 2, 1'b0);
      mask = 0;
      for (int f = 0; f < 6; f++) begin
         fill_ab(2, 4);
         run_frame();
         compare_frame("skip");
         if (act_q.size() > 0) mask |= (1 << f);
         clear_q();
      end
      check("skip_frame_mask", 64'(mask), 64'(6'b001001));
      check("skip_frame_cnt", 64'(frame_cnt_o), 64'(2));

      // Randomized frames.
      for (int f = 0; f < 20; f++) begin
         if ($urandom_range(0, 2) == 0) set_cfg(0, 4095, 0, 4095, $urandom_range(0, 3), 1'($urandom));
         else set_cfg($urandom_range(0, 6), $urandom_range(0, 9), $urandom_range(0, 3),
                      $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom));
         fill_rand($urandom_range(1, 5), 20);
         run_frame();
         compare_frame("random");
         clear_q();
      end

      // Reset in the middle of a line.
      set_cfg(0, 4095, 0, 4095, 0, 1'b0);
      repeat (3) tick(1'b1, 1'b0, 8'h00);
      tick(1'b0, 1'b0, 8'h00);
      tick(1'b0, 1'b0, 8'h00);
      for (int b = 0; b < 5; b++) tick(1'b0, 1'b1, 8'h5A + 8'(b));
      #2;
      rst = 1'b1;
      #1;
      check("midrst_pdata", 64'(pdata_o), 64'(0));
      check("midrst_de", 64'(de_o), 64'(0));
      check("midrst_sof", 64'(sof_o), 64'(0));
      check("midrst_eol", 64'(eol_o), 64'(0));
      check("midrst_frame_cnt", 64'(frame_cnt_o), 64'(0));
      check("midrst_err", 64'(err_o), 64'(0));
      tick(1'b0, 1'b1, 8'h11);
      rst = 1'b0;
      m_skip = 0;
      m_fcnt = 0;
      clear_q();
      for (int l = 0; l < 3; l++) begin
         for (int b = 0; b < 7; b++) tick(1'b0, 1'b1, 8'($urandom));
         repeat (2) tick(1'b0, 1'b0, 8'h00);
      end
      repeat (3) @(negedge pclk);
      check("midrst_no_pix", 64'(act_q.size()), 64'(0));
      check("midrst_no_err", 64'(act_err.size()), 64'(0));
      clear_q();
      fill_ab(2, 8);
      run_frame();
      compare_frame("postrst");
      check("postrst_frame_cnt", 64'(frame_cnt_o), 64'(1));
      clear_q();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cmos_pixel_capture.md
# cmos_pixel_capture

Parametrised successor to the camera 8-to-16-bit byte packer. Packs BYTES_PER_PIX consecutive sensor bytes into one pixel word, with selectable byte order and RGB565 red/blue swap. Adds per-frame crop windowing, frame decimation, frame counting and partial-pixel error detection. Sits between the camera pins and the video FIFO write port, entirely in the cmos_pclk domain.

## Interface
Parameters:
- IN_W, 8, sensor data bus width
- BYTES_PER_PIX, 2, bus words per pixel (1..4)
- OUT_W, IN_W*BYTES_PER_PIX, output pixel width (derived, do not override)
- CNT_W, 12, width of x/y counters and crop bounds
- MSB_FIRST, 1, 1: first byte of pixel lands in pdata_o MSBs; 0: in LSBs

Ports:
- pclk  in  1  sensor pixel clock; the only clock
- rst  in  1  asynchronous, active-high reset
- pdata_i  in  IN_W  sensor data
- vsync_i  in  1  sensor vsync, high during vertical blank
- href_i  in  1  sensor href, high while line bytes valid
- x_start_i, x_end_i  in  CNT_W each  inclusive horizontal crop, in pixels
- y_start_i, y_end_i  in  CNT_W each  inclusive vertical crop, in lines
- skip_i  in  4  keep 1 frame out of every skip_i+1
- rb_swap_i  in  1  swap bits [15:11] and [4:0] (valid only when OUT_W==16)
- pdata_o  out  OUT_W  packed pixel
- de_o  out  1  pixel valid strobe
- sof_o  out  1  first de_o of an accepted frame
- eol_o  out  1  de_o of pixel at x == x_end
- frame_cnt_o  out  16  accepted-frame count, wraps
- err_o  out  1  one-cycle pulse: line ended mid-pixel

## Operation
- Input stage: pdata_i, vsync_i and href_i are registered every pclk. All logic below uses these registered copies (d_r, vs_r, hr_r).
- Frame start: falling edge of vs_r.
  - Latches all crop bounds, skip_i and rb_swap_i into shadow registers. Mid-frame config changes have no effect.
  - Clears x, y, phase and the first-pixel flag.
  - Sets frame_active.
  - accept = (skip_cnt == 0). skip_cnt then advances modulo skip_i+1 (new skip_i used).
  - frame_cnt_o increments when accept = 1.
- vs_r high: forces frame_active = 0. Any partially assembled pixel is discarded with no err_o.
- Byte packing: while frame_active && hr_r, each cycle shifts d_r into the assembly register and increments phase.
  - At phase == BYTES_PER_PIX-1 a pixel completes and phase returns to 0.
  - MSB_FIRST=1: byte 0 occupies bits [OUT_W-1 : OUT_W-IN_W].
  - rb_swap applies as pdata_o = {p[4:0], p[10:5], p[15:11]}.
- Pixel emit: on completion, pdata_o is loaded. de_o = accept && x_start ≤ x ≤ x_end && y_start ≤ y ≤ y_end (x, y are pre-increment values). Then x increments, saturating at all-ones.
- sof_o = de_o && first-pixel flag; the flag clears on the first de_o of the frame.
- eol_o = de_o && x == x_end.
- Line end: falling edge of hr_r.
  - If phase ≠ 0, the partial pixel is dropped and err_o pulses.
  - x and phase clear.
  - y increments (saturating) if at least one byte was seen on the line.
- Reset mid-frame: frame_active = 0. No output until the next vsync falling edge, so the first partial frame is always dropped.
- BYTES_PER_PIX = 1: every byte is one pixel; err_o never fires.

## Timing
- Reset values: pdata_o = 0, de_o = 0, sof_o = 0, eol_o = 0, frame_cnt_o = 0, err_o = 0, skip_cnt = 0, frame_active = 0.
- Latency: the last byte of a pixel is present on pdata_i before pclk edge N, registered at edge N, and de_o/pdata_o are valid after edge N+1 (2-cycle latency).
- de_o, sof_o and eol_o are single-cycle pulses. pdata_o holds until the next pixel.
- err_o asserts 2 cycles after the first cycle href_i is sampled low.
- Simultaneous vs_r fall and hr_r high: frame start takes priority. Bytes in that cycle are not captured, and capture begins the next cycle.
- x_start > x_end or y_start > y_end: no de_o for the frame. frame_cnt_o still counts it.
- Throughput: at most one pixel per BYTES_PER_PIX cycles. No backpressure.

## Test plan
- Defaults, crop 0..3 × 0..1, skip 0: 2 lines × 4 pixels of bytes A0,B0,A1,B1… → 8 de_o with pdata_o = 16'hA0B0 first; sof_o on pixel 0; eol_o on x=3 of each line; frame_cnt_o = 1.
- rb_swap_i = 1, bytes 8'hF8, 8'h1F (0xF81F) → pdata_o = 16'h1F…: bits {0x1F, 0x00, 0x1F} → 16'hF81F swapped becomes 16'hF81F→{11111,000000,11111} = 16'hF81F; use 0xF800 → required 16'h001F.
- Crop x 2..3, y 1..1 on a 4×3 frame → exactly 2 de_o, both on line 1; sof_o on the first; eol_o on the second.
- skip_i = 2 over 6 frames → pixels only in frames 1 and 4; frame_cnt_o = 2.
- Line with 7 bytes (BYTES_PER_PIX=2) → 3 de_o, then one err_o pulse 2 cycles after href falls; next line is packed correctly from phase 0.
- Assert rst mid-line → all outputs 0 immediately; no de_o until after the next vsync falling edge; frame_cnt_o restarts at 1.
